// File: rtl/xcvr_reset_sequencer_pkg.sv
// Shared types for the transceiver reset sequencer: state encoding, retry width
// and the per-state output decode.
package xcvr_reset_sequencer_pkg;

  localparam int RETRY_W = 2;

  typedef enum logic [2:0] {
    S_PLL_RST     = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_GT_RST      = 3'd3,
    S_REL_PCS     = 3'd4,
    S_REL_MAC     = 3'd5,
    S_READY       = 3'd6,
    S_FAULT       = 3'd7
  } state_t;

  typedef struct packed {
    logic qpll;
    logic gt_tx;
    logic gt_rx;
    logic pcs;
    logic mac;
    logic ready;
    logic fault;
  } outs_t;

  function automatic outs_t decode_outputs(state_t s);
    outs_t o;
    o = '{qpll: 1'b1, gt_tx: 1'b1, gt_rx: 1'b1, pcs: 1'b1, mac: 1'b1,
          ready: 1'b0, fault: 1'b0};
    case (s)
      S_WAIT_LOCK, S_LOCK_STABLE: o.qpll = 1'b0;
      S_GT_RST: begin
        o.qpll  = 1'b0;
        o.gt_tx = 1'b0;
        o.gt_rx = 1'b0;
      end
      S_REL_PCS: o = '{qpll: 1'b0, gt_tx: 1'b0, gt_rx: 1'b0, pcs: 1'b0, mac: 1'b1,
                       ready: 1'b0, fault: 1'b0};
      S_REL_MAC: o = '{qpll: 1'b0, gt_tx: 1'b0, gt_rx: 1'b0, pcs: 1'b0, mac: 1'b0,
                       ready: 1'b0, fault: 1'b0};
      S_READY:   o = '{qpll: 1'b0, gt_tx: 1'b0, gt_rx: 1'b0, pcs: 1'b0, mac: 1'b0,
                       ready: 1'b1, fault: 1'b0};
      S_FAULT:   o.fault = 1'b1;
      default:   ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/xcvr_reset_sequencer_sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous status inputs. No reset.
module xcvr_reset_sequencer_sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_p0;
  (* ASYNC_REG = "TRUE" *) logic sync_p1;

  always_ff @(posedge clk) begin
    meta_p0 <= d;
    sync_p1 <= meta_p0;
  end

  assign q = sync_p1;

endmodule

// File: rtl/xcvr_reset_sequencer.sv
// Power-up / recovery reset sequencer for the 10G transceiver path: QPLL, GT,
// PCS, MAC release in order, with timeout retries and a sticky fault.
module xcvr_reset_sequencer #(
  parameter int PLL_RST_CYC      = 32,
  parameter int LOCK_TIMEOUT_CYC = 125000,
  parameter int STABLE_CYC       = 1250,
  parameter int GT_TIMEOUT_CYC   = 125000,
  parameter int GAP_CYC          = 16,
  parameter int MAX_RETRY        = 3
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_QPLL_LOCK,
  input  logic       i_TX_RESET_DONE,
  input  logic       i_RX_RESET_DONE,
  input  logic       i_MAN_RESET,
  output logic       o_QPLL_RESET,
  output logic       o_GT_TX_RESET,
  output logic       o_GT_RX_RESET,
  output logic       o_PCS_RESET,
  output logic       o_MAC_RESET,
  output logic       o_READY,
  output logic       o_FAULT,
  output logic [2:0] o_STATE,
  output logic [1:0] o_RETRY_CNT
);
  import xcvr_reset_sequencer_pkg::*;

  localparam int MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CD  = (STABLE_CYC > GT_TIMEOUT_CYC) ? STABLE_CYC : GT_TIMEOUT_CYC;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_CYC = (MAX_ABC > GAP_CYC) ? MAX_ABC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]   PLL_LAST    = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   GT_LAST     = CNT_W'(GT_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'(GAP_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  logic lock_s, tx_done_s, rx_done_s;

  xcvr_reset_sequencer_sync_2ff u_sync_lock (.clk(i_CLK), .d(i_QPLL_LOCK),     .q(lock_s));
  xcvr_reset_sequencer_sync_2ff u_sync_tx   (.clk(i_CLK), .d(i_TX_RESET_DONE), .q(tx_done_s));
  xcvr_reset_sequencer_sync_2ff u_sync_rx   (.clk(i_CLK), .d(i_RX_RESET_DONE), .q(rx_done_s));

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic               timeout;
  outs_t              outs_q;

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    timeout   = 1'b0;
    if (i_MAN_RESET) begin
      state_nxt = S_PLL_RST;
      retry_nxt = '0;
    end else begin
      case (state)
        S_PLL_RST:     if (cnt == PLL_LAST) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK:   if (lock_s) state_nxt = S_LOCK_STABLE;
                       else if (cnt == LOCK_LAST) timeout = 1'b1;
        S_LOCK_STABLE: if (!lock_s) state_nxt = S_WAIT_LOCK;
                       else if (cnt == STABLE_LAST) state_nxt = S_GT_RST;
        S_GT_RST:      if (!lock_s) state_nxt = S_PLL_RST;
                       else if (tx_done_s && rx_done_s) state_nxt = S_REL_PCS;
                       else if (cnt == GT_LAST) timeout = 1'b1;
        S_REL_PCS:     if (!lock_s) state_nxt = S_PLL_RST;
                       else if (cnt == GAP_LAST) state_nxt = S_REL_MAC;
        S_REL_MAC:     if (!lock_s) state_nxt = S_PLL_RST;
                       else if (cnt == GAP_LAST) begin
                         state_nxt = S_READY;
                         retry_nxt = '0;
                       end
        S_READY:       if (!lock_s) state_nxt = S_PLL_RST;
        default:       ;
      endcase
      if (timeout) begin
        if (retry == RETRY_MAX) begin
          state_nxt = S_FAULT;
        end else begin
          state_nxt = S_PLL_RST;
          retry_nxt = retry + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= S_PLL_RST;
      cnt     <= '0;
      retry   <= '0;
      outs_q  <= decode_outputs(S_PLL_RST);
      o_STATE <= 3'd0;
    end else begin
      state   <= state_nxt;
      retry   <= retry_nxt;
      outs_q  <= decode_outputs(state_nxt);
      o_STATE <= state_nxt;
      if (state_nxt != state || i_MAN_RESET)
        cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + 1'b1;
    end
  end

  assign o_QPLL_RESET  = outs_q.qpll;
  assign o_GT_TX_RESET = outs_q.gt_tx;
  assign o_GT_RX_RESET = outs_q.gt_rx;
  assign o_PCS_RESET   = outs_q.pcs;
  assign o_MAC_RESET   = outs_q.mac;
  assign o_READY       = outs_q.ready;
  assign o_FAULT       = outs_q.fault;
  assign o_RETRY_CNT   = retry;

endmodule

// File: tb/tb_xcvr_reset_sequencer.sv
// Bench for xcvr_reset_sequencer: directed scenarios plus random lock/done
// activity, every cycle compared against a behavioural reference model.
module tb_xcvr_reset_sequencer;

  localparam int PLL_RST_CYC      = 8;
  localparam int LOCK_TIMEOUT_CYC = 100;
  localparam int STABLE_CYC       = 20;
  localparam int GT_TIMEOUT_CYC   = 50;
  localparam int GAP_CYC          = 4;
  localparam int MAX_RETRY        = 3;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic rst, lock, tx_done, rx_done, man;
  logic o_qpll, o_gt_tx, o_gt_rx, o_pcs, o_mac, o_ready, o_fault;
  logic [2:0] o_state;
  logic [1:0] o_retry;

  xcvr_reset_sequencer #(
    .PLL_RST_CYC(PLL_RST_CYC), .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
    .STABLE_CYC(STABLE_CYC), .GT_TIMEOUT_CYC(GT_TIMEOUT_CYC),
    .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_QPLL_LOCK(lock),
    .i_TX_RESET_DONE(tx_done), .i_RX_RESET_DONE(rx_done), .i_MAN_RESET(man),
    .o_QPLL_RESET(o_qpll), .o_GT_TX_RESET(o_gt_tx), .o_GT_RX_RESET(o_gt_rx),
    .o_PCS_RESET(o_pcs), .o_MAC_RESET(o_mac), .o_READY(o_ready), .o_FAULT(o_fault),
    .o_STATE(o_state), .o_RETRY_CNT(o_retry)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase index, cycles spent in the phase, retries used,
  // and the two-stage view of each asynchronous input.
  int m_ph = 0, m_t = 0, m_retry = 0;
  bit l1 = 0, l2 = 0, t1 = 0, t2 = 0, r1 = 0, r2 = 0;
  bit [4:0] rst_tab [8] = '{5'b11111, 5'b01111, 5'b01111, 5'b00011,
                            5'b00001, 5'b00000, 5'b00000, 5'b11111};

  task automatic model_edge();
    int nph;
    bit to;
    if (rst) begin
      m_ph = 0; m_t = 0; m_retry = 0;
    end else if (man) begin
      m_ph = 0; m_t = 0; m_retry = 0;
    end else begin
      nph = m_ph;
      to  = 0;
      if (m_ph >= 3 && m_ph <= 6 && !l2) nph = 0;
      else if (m_ph == 0 && m_t == PLL_RST_CYC - 1) nph = 1;
      else if (m_ph == 1) begin
        if (l2) nph = 2;
        else if (m_t == LOCK_TIMEOUT_CYC - 1) to = 1;
      end else if (m_ph == 2) begin
        if (!l2) nph = 1;
        else if (m_t == STABLE_CYC - 1) nph = 3;
      end else if (m_ph == 3) begin
        if (t2 && r2) nph = 4;
        else if (m_t == GT_TIMEOUT_CYC - 1) to = 1;
      end else if (m_ph == 4 && m_t == GAP_CYC - 1) nph = 5;
      else if (m_ph == 5 && m_t == GAP_CYC - 1) begin
        nph = 6; m_retry = 0;
      end
      if (to) begin
        if (m_retry == MAX_RETRY) nph = 7;
        else begin nph = 0; m_retry = m_retry + 1; end
      end
      m_t = (nph != m_ph) ? 0 : m_t + 1;
      m_ph = nph;
    end
    l2 = l1; l1 = lock;
    t2 = t1; t1 = tx_done;
    r2 = r1; r1 = rx_done;
  endtask

  int cyc = 0;
  int fall_q, fall_gt, fall_pcs, fall_mac, rise_rdy;
  logic p_q, p_gt, p_pcs, p_mac, p_rdy;

  task automatic tick(input string tag);
    logic [11:0] act, exp;
    p_q = o_qpll; p_gt = o_gt_tx; p_pcs = o_pcs; p_mac = o_mac; p_rdy = o_ready;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (p_q && !o_qpll)     fall_q   = cyc;
    if (p_gt && !o_gt_tx)   fall_gt  = cyc;
    if (p_pcs && !o_pcs)    fall_pcs = cyc;
    if (p_mac && !o_mac)    fall_mac = cyc;
    if (!p_rdy && o_ready)  rise_rdy = cyc;
    act = {o_state, o_retry, o_ready, o_fault, o_qpll, o_gt_tx, o_gt_rx, o_pcs, o_mac};
    exp = {3'(m_ph), 2'(m_retry), m_ph == 6, m_ph == 7, rst_tab[m_ph]};
    chk(tag, 32'(act), 32'(exp));
  endtask

  task automatic run_until_state(input string tag, input int st, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_state == 3'(st)) break;
      tick(tag);
    end
    chk({tag, "_reached"}, 32'(o_state), 32'(st));
  endtask

  task automatic man_pulse(input string tag);
    man = 1'b1;
    tick(tag);
    man = 1'b0;
  endtask

  int t0;

  initial begin
    rst = 1'b1; lock = 1'b0; tx_done = 1'b0; rx_done = 1'b0; man = 1'b0;
    repeat (4) tick("reset");
    chk("reset_state", 32'(o_state), 0);
    chk("reset_resets", 32'({o_qpll, o_gt_tx, o_gt_rx, o_pcs, o_mac}), 32'h1f);
    chk("reset_flags", 32'({o_ready, o_fault, o_retry}), 0);

    // Nominal bring-up
    fall_q = -1; fall_gt = -1; fall_pcs = -1; fall_mac = -1; rise_rdy = -1;
    rst = 1'b0;
    cyc = 0;
    while (cyc < 15) tick("nominal");
    lock = 1'b1;
    run_until_state("nom_gt", 3, 200);
    repeat (10) tick("nominal");
    tx_done = 1'b1; rx_done = 1'b1;
    run_until_state("nom_ready", 6, 200);
    chk("nom_qpll_at_8", 32'(fall_q), 32'(PLL_RST_CYC));
    chk("nom_order_gt", 32'(fall_gt > fall_q), 1);
    chk("nom_order_pcs", 32'(fall_pcs > fall_gt), 1);
    chk("nom_mac_gap", 32'(fall_mac - fall_pcs), 32'(GAP_CYC));
    chk("nom_ready_gap", 32'(rise_rdy - fall_mac), 32'(GAP_CYC));
    chk("nom_retry", 32'(o_retry), 0);

    // Lock loss in READY
    lock = 1'b0;
    run_until_state("rdy_loss", 0, 5);
    chk("rdy_loss_ready", 32'(o_ready), 0);
    chk("rdy_loss_resets", 32'({o_qpll, o_gt_tx, o_gt_rx, o_pcs, o_mac}), 32'h1f);
    lock = 1'b1;
    run_until_state("rdy_again", 6, 300);

    // Lock glitch during LOCK_STABLE
    man_pulse("glitch");
    run_until_state("glitch_stable", 2, 100);
    repeat (8) tick("glitch");
    lock = 1'b0;
    repeat (3) tick("glitch");
    lock = 1'b1;
    run_until_state("glitch_back", 1, 6);
    chk("glitch_gt_held", 32'({o_gt_tx, o_gt_rx}), 32'h3);
    chk("glitch_retry", 32'(o_retry), 0);
    run_until_state("glitch_restable", 2, 10);
    t0 = cyc;
    run_until_state("glitch_gt", 3, 40);
    chk("glitch_stable_len", 32'(cyc - t0), 32'(STABLE_CYC));
    run_until_state("glitch_ready", 6, 100);

    // GT done timeout once, then success
    tx_done = 1'b0; rx_done = 1'b0;
    man_pulse("gt_to");
    run_until_state("gt_to_gt", 3, 100);
    for (int i = 0; i < 100 && o_retry != 2'd1; i++) tick("gt_to");
    chk("gt_to_retry1", 32'(o_retry), 1);
    tx_done = 1'b1; rx_done = 1'b1;
    run_until_state("gt_to_ready", 6, 300);
    chk("gt_to_retry0", 32'(o_retry), 0);

    // Reset pulse during REL_PCS
    man_pulse("rst_pcs");
    run_until_state("rst_pcs_in", 4, 300);
    rst = 1'b1;
    tick("rst_pcs");
    rst = 1'b0;
    chk("rst_pcs_state", 32'(o_state), 0);
    chk("rst_pcs_resets", 32'({o_qpll, o_gt_tx, o_gt_rx, o_pcs, o_mac}), 32'h1f);
    run_until_state("rst_pcs_ready", 6, 300);

    // No lock: retries exhausted, then FAULT
    lock = 1'b0;
    man_pulse("fault");
    run_until_state("fault", 7, 1000);
    chk("fault_flag", 32'(o_fault), 1);
    chk("fault_retry", 32'(o_retry), 3);
    repeat (10) tick("fault_hold");
    chk("fault_sticky", 32'(o_state), 7);
    chk("fault_resets", 32'({o_qpll, o_gt_tx, o_gt_rx, o_pcs, o_mac}), 32'h1f);
    man_pulse("fault_exit");
    chk("fault_exit_state", 32'(o_state), 0);
    chk("fault_exit_retry", 32'(o_retry), 0);

    // Random activity
    lock = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (lock ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 19) == 0)) lock = ~lock;
      if ($urandom_range(0, 29) == 0) tx_done = ~tx_done;
      if ($urandom_range(0, 29) == 0) rx_done = ~rx_done;
      man = ($urandom_range(0, 499) == 0);
      rst = ($urandom_range(0, 799) == 0);
      tick("random");
    end
    man = 1'b0; rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
